// File: rtl/bcd_conv_sched_pkg.sv
// Shared types and sizing helpers for the BCD converter scheduler.
//   state_t      : scheduler FSM states
//   id_width()   : requester index width (at least 1 bit)
//   tcnt_width() : width of the completion timeout counter
package bcd_conv_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_CLR,
        WAIT_SET,
        RESP
    } state_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned ID_W      = id_width(DEF_N_REQ);

    // Holds values 0..t-1, the last one being the timeout threshold.
    function automatic int unsigned tcnt_width(input int unsigned t);
        return (t < 2) ? 1 : $clog2(t);
    endfunction

endpackage

// File: rtl/bcd_conv_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : highest-priority index this cycle (register lives in the parent)
//   en  : when low, no grant is produced
//   gnt : one-hot grant
//   idx : encoded index of the granted requester
//   any : a grant was produced
module rr_arbiter
    import bcd_conv_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    input  logic                     en,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     any
);

    localparam int unsigned IDW = id_width(N_REQ);

    int unsigned     pos;
    logic [IDW-1:0]  sel;

    // Scan from ptr upward, wrapping modulo N_REQ; first request found wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        sel = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = (32'(ptr) + k) % N_REQ;
            sel = IDW'(pos);
            if (en && !any && req[sel]) begin
                any      = 1'b1;
                gnt[sel] = 1'b1;
                idx      = sel;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one binary-to-BCD converter among N_REQ
// requesters.
//   req_valid/req_data/req_ready : per-requester request handshake
//   rsp_valid/rsp_ready          : response handshake
//   rsp_id/rsp_digits/rsp_error  : served index, BCD digits, timeout flag
//   cnv_write/cnv_data           : converter load strobe and operand
//   cnv_done/cnv_digits          : converter completion flag and result
//   busy                         : high whenever a transaction is open
module bcd_conv_sched
    import bcd_conv_sched_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DIGIT_COUNT = 3,
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [DIGIT_COUNT*4-1:0]   rsp_digits,
    output logic                       rsp_error,
    output logic                       cnv_write,
    output logic [WIDTH-1:0]           cnv_data,
    input  logic                       cnv_done,
    input  logic [DIGIT_COUNT*4-1:0]   cnv_digits,
    output logic                       busy
);

    localparam int unsigned IDW = id_width(N_REQ);
    localparam int unsigned TW  = tcnt_width(TIMEOUT);
    localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT - 1);

    state_t                   state, state_nx;
    logic [IDW-1:0]           rr_ptr;
    logic [IDW-1:0]           id_q;
    logic [TW-1:0]            tcnt;
    logic [WIDTH-1:0]         cnv_data_q;
    logic [DIGIT_COUNT*4-1:0] rsp_digits_q;
    logic [IDW-1:0]           rsp_id_q;
    logic                     rsp_error_q;

    logic [N_REQ-1:0]         gnt;
    logic [IDW-1:0]           gnt_idx;
    logic                     gnt_any;
    logic                     arb_en;

    logic                     ld_grant, ld_ok, ld_to, tcnt_clr, tcnt_inc;

    // Gating with rst_n keeps req_ready low while reset is held, even
    // though the state register already reads IDLE.
    assign arb_en = (state == IDLE) && rst_n;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .en  (arb_en),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign req_ready  = gnt;
    assign cnv_data   = cnv_data_q;
    assign rsp_digits = rsp_digits_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_error  = rsp_error_q;

    always_comb begin
        state_nx  = state;
        cnv_write = 1'b0;
        rsp_valid = 1'b0;
        busy      = (state != IDLE);
        ld_grant  = 1'b0;
        ld_ok     = 1'b0;
        ld_to     = 1'b0;
        tcnt_clr  = 1'b0;
        tcnt_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    ld_grant = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                cnv_write = 1'b1;
                tcnt_clr  = 1'b1;
                state_nx  = WAIT_CLR;
            end
            // A done flag still high from the previous conversion must
            // fall before the rising edge can be trusted.
            WAIT_CLR: begin
                if (tcnt == T_LIM) begin
                    ld_to    = 1'b1;
                    state_nx = RESP;
                end else begin
                    tcnt_inc = 1'b1;
                    if (!cnv_done) state_nx = WAIT_SET;
                end
            end
            WAIT_SET: begin
                if (cnv_done) begin
                    ld_ok    = 1'b1;
                    state_nx = RESP;
                end else if (tcnt == T_LIM) begin
                    ld_to    = 1'b1;
                    state_nx = RESP;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            id_q         <= '0;
            tcnt         <= '0;
            cnv_data_q   <= '0;
            rsp_digits_q <= '0;
            rsp_id_q     <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (ld_grant) begin
                cnv_data_q <= req_data[32'(gnt_idx) * WIDTH +: WIDTH];
                id_q       <= gnt_idx;
                rr_ptr     <= (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (tcnt_clr) begin
                tcnt <= '0;
            end else if (tcnt_inc) begin
                tcnt <= tcnt + 1'b1;
            end
            if (ld_ok) begin
                rsp_digits_q <= cnv_digits;
                rsp_id_q     <= id_q;
                rsp_error_q  <= 1'b0;
            end else if (ld_to) begin
                rsp_digits_q <= '0;
                rsp_id_q     <= id_q;
                rsp_error_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_conv_sched.sv
module tb_bcd_conv_sched;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int DC  = 3;
    localparam int DCW = DC * 4;
    localparam int TO  = 64;
    localparam int L   = W;     // converter model latency (cycles done is low)
    localparam int IDW = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [DCW-1:0]   rsp_digits;
    logic             rsp_error;
    logic             cnv_write;
    logic [W-1:0]     cnv_data;
    logic             cnv_done;
    logic [DCW-1:0]   cnv_digits;
    logic             busy;

    bcd_conv_sched #(.WIDTH(W), .DIGIT_COUNT(DC), .N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_digits(rsp_digits), .rsp_error(rsp_error),
        .cnv_write(cnv_write), .cnv_data(cnv_data),
        .cnv_done(cnv_done), .cnv_digits(cnv_digits), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int             id;
        logic [DCW-1:0] dig;
        logic           err;
    } rsp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   wr_cnt = 0;
    int   gr_cnt = 0;
    rsp_t resp_q[$];
    int   gq[$];
    bit   next_never = 1'b0;
    int   next_D = 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [DCW-1:0] to_bcd(input int unsigned v);
        logic [DCW-1:0] r;
        r = '0;
        for (int i = 0; i < DC; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] out_vec();
        return 64'({req_ready, rsp_valid, rsp_id, rsp_digits, rsp_error,
                    cnv_write, cnv_data, busy});
    endfunction

    // Converter model: done drops next_D cycles after the write (stale level
    // and digits held until then), stays low L cycles, then rises with the
    // BCD of the operand. In "never" mode done stays low.
    initial begin : conv_model
        bit             hw, cur_never, old_done;
        int             wr_c, cur_D;
        logic [W-1:0]   new_v;
        logic [DCW-1:0] old_dig;
        hw = 1'b0; cur_never = 1'b0; old_done = 1'b0; wr_c = 0; cur_D = 1;
        new_v = '0; old_dig = '0;
        cnv_done = 1'b0;
        cnv_digits = '0;
        forever begin
            @(negedge clk);
            if (cnv_write === 1'b1) begin
                hw = 1'b1; wr_c = cyc; new_v = cnv_data;
                old_dig = cnv_digits; old_done = cnv_done;
                cur_never = next_never; cur_D = next_D;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (hw) begin
                if (cyc < wr_c + cur_D) begin
                    cnv_done = old_done;
                    cnv_digits = old_dig;
                end else if (cur_never || cyc < wr_c + cur_D + L) begin
                    cnv_done = 1'b0;
                    cnv_digits = DCW'($urandom);
                end else begin
                    cnv_done = 1'b1;
                    cnv_digits = to_bcd(new_v);
                end
            end
        end
    end

    // Transaction-level reference: one transaction at a time, round-robin
    // grant from a pointer, write one cycle after grant, response at the
    // cycle implied by the converter timing, idle again after handshake.
    initial begin : compare
        int ph, mptr, eid, g, wr, rsp_at;
        logic [W-1:0] edata;
        logic         eerr;
        logic [N-1:0] eg;
        ph = 0; mptr = 0; eid = 0; g = 0; wr = 0; rsp_at = 0;
        edata = '0; eerr = 1'b0; eg = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ph = 0; mptr = 0;
                chk("reset_outputs", out_vec(), 64'd0);
                continue;
            end
            if (cnv_write === 1'b1) wr_cnt++;
            if (|req_ready) gr_cnt++;
            if (ph == 2 && cyc >= rsp_at) ph = 3;
            eg = '0; g = 0;
            if (ph == 0) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (mptr + k) % N;
                    if (req_valid[j] && eg == '0) begin
                        eg[j] = 1'b1;
                        g = j;
                    end
                end
            end
            chk("req_ready", 64'(req_ready), 64'(eg));
            chk("busy", 64'(busy), 64'(ph != 0));
            chk("cnv_write", 64'(cnv_write), 64'(ph == 1));
            chk("rsp_valid", 64'(rsp_valid), 64'(ph == 3));
            case (ph)
                0: if (eg != '0) begin
                    eid = g;
                    edata = req_data[g*W +: W];
                    mptr = (g + 1) % N;
                    gq.push_back(g);
                    ph = 1;
                end
                1: begin
                    chk("cnv_data", 64'(cnv_data), 64'(edata));
                    wr = cyc;
                    eerr = next_never;
                    rsp_at = next_never ? wr + TO + 1 : wr + next_D + L + 1;
                    ph = 2;
                end
                2: chk("cnv_data_hold", 64'(cnv_data), 64'(edata));
                default: begin
                    chk("rsp_id", 64'(rsp_id), 64'(eid));
                    chk("rsp_digits", 64'(rsp_digits), eerr ? 64'd0 : 64'(to_bcd(edata)));
                    chk("rsp_error", 64'(rsp_error), 64'(eerr));
                    chk("cnv_data_hold", 64'(cnv_data), 64'(edata));
                    if (rsp_ready) begin
                        resp_q.push_back('{int'(rsp_id), rsp_digits, rsp_error});
                        ph = 0;
                    end
                end
            endcase
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_resp(input int target, input string nm);
        int t;
        t = 0;
        while (resp_q.size() < target && t < 400) begin
            @(negedge clk); #1; t++;
        end
        chk(nm, 64'(resp_q.size()), 64'(target));
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 400) begin
            @(negedge clk); #1; t++;
        end
        chk(nm, 64'(busy), 64'd0);
    endtask

    // Single-requester transaction; valid is dropped right after the grant.
    task automatic serve_one(input int p, input logic [W-1:0] d, input string nm, output rsp_t r);
        int  r0, t;
        bit  got;
        r0 = resp_q.size();
        @(posedge clk); #1;
        req_data[p*W +: W] = d;
        req_valid[p] = 1'b1;
        got = 1'b0; t = 0;
        while (!got && t < 200) begin
            @(negedge clk); #1; t++;
            if (req_ready[p]) got = 1'b1;
        end
        chk({nm, "_grant"}, 64'(got), 64'd1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        wait_resp(r0 + 1, {nm, "_resp"});
        r = '{-1, '1, 1'bx};
        if (resp_q.size() > r0) r = resp_q[r0];
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin : main
        rsp_t r;
        int   r0, g0, w0, t, s_gr, s_wr;
        logic [DCW-1:0] exp_d [4];
        rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t0_reset_zero", out_vec(), 64'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;

        // Single request, port 2, 255
        g0 = gr_cnt; w0 = wr_cnt;
        serve_one(2, 8'd255, "t1", r);
        chk("t1_id", 64'(r.id), 64'd2);
        chk("t1_digits", 64'(r.dig), 64'h255);
        chk("t1_err", 64'(r.err), 64'd0);
        chk("t1_cnv_data", 64'(cnv_data), 64'd255);
        chk("t1_one_grant", 64'(gr_cnt - g0), 64'd1);
        chk("t1_one_write", 64'(wr_cnt - w0), 64'd1);
        wait_idle("t1_idle");

        // All four ports continuously valid, rsp_ready high, from pointer 0
        apply_reset();
        r0 = resp_q.size(); g0 = gq.size();
        req_data = {8'd40, 8'd30, 8'd20, 8'd10};
        req_valid = '1;
        wait_resp(r0 + 5, "t2_resp");
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle("t2_idle");
        exp_d = '{12'h010, 12'h020, 12'h030, 12'h040};
        for (int k = 0; k < 5; k++) begin
            if (gq.size() > g0 + k) chk("t2_grant_order", 64'(gq[g0 + k]), 64'(k % N));
            if (resp_q.size() > r0 + k) begin
                chk("t2_rsp_id", 64'(resp_q[r0 + k].id), 64'(k % N));
                chk("t2_rsp_digits", 64'(resp_q[r0 + k].dig), 64'(exp_d[k % N]));
            end
        end

        // Back-pressure, with another requester waiting
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_data[0*W +: W] = 8'd99; req_valid[0] = 1'b1;
        req_data[3*W +: W] = 8'd5;
        t = 0;
        while (!req_ready[0] && t < 200) begin @(negedge clk); #1; t++; end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        req_valid[3] = 1'b1;
        t = 0;
        while (!rsp_valid && t < 200) begin @(negedge clk); #1; t++; end
        s_gr = gr_cnt; s_wr = wr_cnt;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            chk("t3_hold_valid", 64'(rsp_valid), 64'd1);
            chk("t3_hold_id", 64'(rsp_id), 64'd0);
            chk("t3_hold_digits", 64'(rsp_digits), 64'h099);
        end
        chk("t3_no_grant", 64'(gr_cnt - s_gr), 64'd0);
        chk("t3_no_write", 64'(wr_cnt - s_wr), 64'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("t3_handshake_valid", 64'(rsp_valid), 64'd1);
        @(negedge clk); #1;
        chk("t3_idle_after", 64'(busy), 64'd0);
        chk("t3_next_grant", 64'(req_ready), 64'b1000);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        wait_idle("t3_idle");

        // Stale done from the previous conversion drops 3 cycles after write
        next_D = 3;
        serve_one(1, 8'd7, "t4", r);
        chk("t4_digits", 64'(r.dig), 64'h007);
        chk("t4_err", 64'(r.err), 64'd0);
        next_D = 1;
        wait_idle("t4_idle");

        // Timeout, then a normal transaction
        next_never = 1'b1;
        serve_one(0, 8'd123, "t5", r);
        chk("t5_err", 64'(r.err), 64'd1);
        chk("t5_digits", 64'(r.dig), 64'd0);
        next_never = 1'b0;
        wait_idle("t5_idle");
        serve_one(2, 8'd200, "t5b", r);
        chk("t5b_err", 64'(r.err), 64'd0);
        chk("t5b_digits", 64'(r.dig), 64'h200);
        wait_idle("t5b_idle");

        // Async reset while waiting for done
        @(posedge clk); #1;
        req_data[3*W +: W] = 8'd77; req_valid[3] = 1'b1;
        t = 0;
        while (!cnv_write && t < 200) begin @(negedge clk); #1; t++; end
        repeat (3) @(negedge clk);
        #1;
        chk("t6_busy_before", 64'(busy), 64'd1);
        r0 = resp_q.size();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_zero", out_vec(), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("t6_no_response", 64'(resp_q.size()), 64'(r0));
        serve_one(1, 8'd42, "t6b", r);
        chk("t6b_id", 64'(r.id), 64'd1);
        chk("t6b_digits", 64'(r.dig), 64'h042);
        wait_idle("t6b_idle");

        // Randomized traffic
        r0 = resp_q.size();
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            req_valid  = N'($urandom);
            req_data   = (N*W)'($urandom);
            rsp_ready  = ($urandom % 4) != 0;
            next_D     = 1 + int'($urandom % 3);
            next_never = ($urandom % 20) == 0;
        end
        @(posedge clk); #1;
        req_valid = '0; rsp_ready = 1'b1; next_never = 1'b0; next_D = 1;
        wait_idle("rand_idle");
        chk("rand_activity", 64'(resp_q.size() - r0 >= 10), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
